// File: rtl/uart_cmd_tx_if.sv
// Command-side bundle between the command source / UART TX core and uart_cmd_tx.
// The slave modport is the transmitter's view; master is the environment driving it.
interface uart_cmd_tx_if #(
   parameter int NUM_BYTES = 3
) ();
   logic                   snd_cmd;
   logic [8*NUM_BYTES-1:0] cmd;
   logic                   tx_done;
   logic                   trmt;
   logic [7:0]             tx_data;
   logic                   busy;
   logic                   cmd_cmplt;

   modport master (
      output snd_cmd, cmd, tx_done,
      input  trmt, tx_data, busy, cmd_cmplt
   );

   modport slave (
      input  snd_cmd, cmd, tx_done,
      output trmt, tx_data, busy, cmd_cmplt
   );
endinterface

// File: rtl/uart_cmd_tx.sv
// Splits a NUM_BYTES command word MSB-first into bytes for the UART transmitter.
// Optional `UART_CMD_CHKSUM_EN appends one inverted-sum checksum byte after the command.
module uart_cmd_tx #(
   parameter int NUM_BYTES = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   uart_cmd_tx_if.slave bus
);
   localparam int CMD_W = 8 * NUM_BYTES;
   localparam int CNT_W = $clog2(NUM_BYTES + 2);
`ifdef UART_CMD_CHKSUM_EN
   localparam int LAST_IDX = NUM_BYTES;
`else
   localparam int LAST_IDX = NUM_BYTES - 1;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

   state_t           state, state_nxt;
   logic [CMD_W-1:0] shift;
   logic [CNT_W-1:0] count;
   logic             tx_done_q;
   logic             byte_done;
   logic             accept, send_byte, advance, finish;
   logic [7:0]       next_byte;
   logic             trmt, busy, cmd_cmplt;
   logic [7:0]       tx_data;

   // Only a rising tx_done counts, so a level held over from the previous byte is not re-counted.
   assign byte_done = bus.tx_done & ~tx_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      send_byte = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.snd_cmd) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            send_byte = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (byte_done) begin
               if (count == '0) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  advance   = 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef UART_CMD_CHKSUM_EN
   logic [7:0] sum;

   // Count reaches zero only on the checksum slot; every earlier slot carries a command byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         sum <= '0;
      else if (accept)                    sum <= '0;
      else if (send_byte && count != '0)  sum <= sum + shift[CMD_W-1 -: 8];
   end

   assign next_byte = (count == '0) ? ~sum : shift[CMD_W-1 -: 8];
`else
   assign next_byte = shift[CMD_W-1 -: 8];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trmt      <= 1'b0;
         tx_data   <= 8'h00;
         busy      <= 1'b0;
         cmd_cmplt <= 1'b0;
         count     <= '0;
         shift     <= '0;
         tx_done_q <= 1'b0;
      end else begin
         tx_done_q <= bus.tx_done;
         trmt      <= send_byte;
         if (accept) begin
            shift     <= bus.cmd;
            count     <= CNT_W'(LAST_IDX);
            busy      <= 1'b1;
            cmd_cmplt <= 1'b0;
         end
         if (send_byte) tx_data <= next_byte;
         if (advance) begin
            shift <= shift << 8;
            count <= count - CNT_W'(1);
         end
         if (finish) begin
            busy      <= 1'b0;
            cmd_cmplt <= 1'b1;
         end
      end
   end

   assign bus.trmt      = trmt;
   assign bus.tx_data   = tx_data;
   assign bus.busy      = busy;
   assign bus.cmd_cmplt = cmd_cmplt;
endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: a behavioural UART TX answers trmt with a delayed tx_done level,
// stimulus queues expected bytes and a monitor pops and compares them on every trmt.
module tb_uart_cmd_tx;
   localparam int NB       = 3;
   localparam int BYTE_CYC = 8;
`ifdef UART_CMD_CHKSUM_EN
   localparam int NTX = NB + 1;
`else
   localparam int NTX = NB;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_tx_if #(.NUM_BYTES(NB)) bus ();
   uart_cmd_tx #(.NUM_BYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [7:0]  exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          sent_cnt = 0;
   logic [31:0] rx_word = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

`ifdef UART_CMD_CHKSUM_EN
   function automatic logic [7:0] chk_byte(input logic [23:0] c);
      logic [7:0] s;
      s = c[23:16] + c[15:8] + c[7:0];
      return ~s;
   endfunction
`endif

   task automatic push_cmd(input logic [23:0] c);
      for (int i = 0; i < NB; i++) exp_q.push_back(c[8*(NB-1-i) +: 8]);
`ifdef UART_CMD_CHKSUM_EN
      exp_q.push_back(chk_byte(c));
`endif
   endtask

   // Issue a one-cycle request; returns 1 time unit after the accepting edge.
   task automatic send(input logic [23:0] c);
      sent_cnt = 0;
      rx_word  = '0;
      push_cmd(c);
      bus.cmd     = c;
      bus.snd_cmd = 1'b1;
      @(posedge clk);
      #1 bus.snd_cmd = 1'b0;
   endtask

   task automatic wait_cmplt(input string name);
      int n;
      n = 0;
      while (!bus.cmd_cmplt && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_cmplt"}, {31'b0, bus.cmd_cmplt}, 32'd1);
      check({name, "_busy"}, {31'b0, bus.busy}, 32'd0);
   endtask

   task automatic check_rx(input string name, input logic [23:0] c);
      check({name, "_count"}, sent_cnt, NTX);
`ifdef UART_CMD_CHKSUM_EN
      check({name, "_rx"}, rx_word, {c, chk_byte(c)});
`else
      check({name, "_rx"}, {8'h00, rx_word[23:0]}, {8'h00, c});
`endif
   endtask

   // Behavioural UART transmitter: tx_done drops on trmt and rises BYTE_CYC cycles later.
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.trmt) begin
            #1 bus.tx_done = 1'b0;
            repeat (BYTE_CYC) @(posedge clk);
            #2 bus.tx_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.trmt) begin
         if (exp_q.size() == 0) begin
            check("extra_trmt", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
         end else begin
            check("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
         end
         sent_cnt++;
         rx_word = {rx_word[23:0], bus.tx_data};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.snd_cmd = 1'b1;
      bus.cmd     = 24'h55AAE3;

      // Reset held with a pending request
      repeat (4) begin
         @(negedge clk);
         check("reset_outs", {21'h0, bus.trmt, bus.tx_data, bus.busy, bus.cmd_cmplt}, 32'h0);
      end
      bus.snd_cmd = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic send with latency check
      send(24'h55AAE3);
      check("t2_busy_accept", {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
      check("t2_trmt_early", {31'b0, bus.trmt}, 32'd0);
      @(negedge clk);
      check("t2_trmt_lat", {31'b0, bus.trmt}, 32'd1);
      check("t2_first_byte", {24'h0, bus.tx_data}, 32'h55);
      wait_cmplt("t2");
      check_rx("t2", 24'h55AAE3);

      // Request while busy is ignored
      @(negedge clk);
      send(24'h55AAE3);
      n = 0;
      while (sent_cnt < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t3_reach_byte2", sent_cnt, 32'd2);
      bus.cmd     = 24'h123456;
      bus.snd_cmd = 1'b1;
      repeat (3) @(negedge clk);
      check("t3_cmplt_busy", {30'b0, bus.cmd_cmplt, bus.busy}, 32'b01);
      bus.snd_cmd = 1'b0;
      wait_cmplt("t3");
      repeat (40) @(negedge clk);
      check_rx("t3", 24'h55AAE3);
      check("t3_idle_busy", {31'b0, bus.busy}, 32'd0);

      // Back-to-back commands
      @(negedge clk);
      send(24'hA5A5A5);
      wait_cmplt("t4a");
      check_rx("t4a", 24'hA5A5A5);
      send(24'h0F0FF0);
      check("t4_cmplt_clear", {30'b0, bus.cmd_cmplt, bus.busy}, 32'b01);
      wait_cmplt("t4b");
      check_rx("t4b", 24'h0F0FF0);

      // Reset after the first byte finishes
      @(negedge clk);
      send(24'h55AAE3);
      n = 0;
      while (sent_cnt < 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!bus.tx_done && n < 200) begin
         @(posedge clk);
         #3;
         n++;
      end
      check("t5_byte1_done", {31'b0, bus.tx_done}, 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t5_reset_now", {21'h0, bus.trmt, bus.tx_data, bus.busy, bus.cmd_cmplt}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_idle_after", {21'h0, bus.trmt, bus.tx_data, bus.busy, bus.cmd_cmplt}, 32'h0);
      send(24'hC33C00);
      wait_cmplt("t5");
      check_rx("t5", 24'hC33C00);

      repeat (20) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
